// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, LSB first, 2-flop input synchronizer.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastBit  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] LastHalf = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            rx_meta;
  logic            rx_s;
  logic            stop_ok;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q;

  assign stop_ok = rx_s && !par_err_q;
`else
  assign stop_ok = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (cnt_q == LastHalf) begin
            cnt_q <= '0;
            // A high line at mid-start is a glitch, not a frame.
            if (rx_s) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == LastBit) begin
            cnt_q          <= '0;
            shift_q[bit_q] <= rx_s;
            bit_q          <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == LastBit) begin
            cnt_q     <= '0;
            par_err_q <= (rx_s != ^shift_q);
            state_q   <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (cnt_q == LastBit) begin
            cnt_q <= '0;
            if (stop_ok) begin
              data       <= shift_q;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            // A low stop bit means the line may be held in break.
            if (rx_s) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx; frames built bit by bit from the serial format,
// expectations kept as a plain byte/event model.
module tb_uart_rx;

  localparam int unsigned CLKS = 16;
  localparam int unsigned HALF = CLKS / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int unsigned FRAME = CLKS * (PAR_EN ? 11 : 10);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int total = 0;
  int bad = 0;

  int n_valid = 0, n_err = 0, n_both = 0;
  int valid_run = 0, err_run = 0, max_valid_run = 0, max_err_run = 0;
  int busy_cycles = 0;
  int cyc = 0, last_valid_cyc = 0, prev_valid_cyc = 0;
  logic busy_at_valid = 1'b0;
  logic [7:0] model_data = 8'h00;

  always @(posedge clk) cyc++;

  // Event recorder only; all judgements happen in the test tasks.
  always @(negedge clk) begin
    if (data_valid) begin
      n_valid++;
      valid_run++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      busy_at_valid  = busy;
    end else begin
      valid_run = 0;
    end
    if (frame_err) begin
      n_err++;
      err_run++;
    end else begin
      err_run = 0;
    end
    if (valid_run > max_valid_run) max_valid_run = valid_run;
    if (err_run > max_err_run) max_err_run = err_run;
    if (data_valid && frame_err) n_both++;
    if (busy) busy_cycles++;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par;
      repeat (CLKS) @(negedge clk);
    end
    rx = stop;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    idle(5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_good_frame;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(4);
    model_data = 8'hA5;
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL good_valid_cnt got=%0d exp=1", n_valid - v0); end
    total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL good_err_cnt got=%0d exp=0", n_err - e0); end
    total++; if (data !== model_data) begin bad++; $display("FAIL good_data got=%h exp=%h", data, model_data); end
    total++; if (busy_at_valid !== 1'b0) begin bad++; $display("FAIL good_busy_at_valid got=%b exp=0", busy_at_valid); end
  endtask

  task automatic test_glitch;
    int v0, e0, b0;
    v0 = n_valid; e0 = n_err; b0 = busy_cycles;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(HALF + 8);
    total++; if (busy_cycles - b0 !== HALF) begin bad++; $display("FAIL glitch_busy_len got=%0d exp=%0d", busy_cycles - b0, HALF); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", n_valid - v0); end
    total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL glitch_err got=%0d exp=0", n_err - e0); end
    total++; if (data !== model_data) begin bad++; $display("FAIL glitch_data got=%h exp=%h", data, model_data); end
  endtask

  task automatic test_framing_err;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    repeat (40) @(negedge clk);
    total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL ferr_err_cnt got=%0d exp=1", n_err - e0); end
    total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL ferr_valid_cnt got=%0d exp=0", n_valid - v0); end
    total++; if (data !== model_data) begin bad++; $display("FAIL ferr_data got=%h exp=%h", data, model_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_break_busy got=%b exp=1", busy); end
    idle(6);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_release_busy got=%b exp=0", busy); end
    total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL ferr_release_err got=%0d exp=1", n_err - e0); end
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(4);
    model_data = 8'h3C;
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL ferr_next_valid got=%0d exp=1", n_valid - v0); end
    total++; if (data !== model_data) begin bad++; $display("FAIL ferr_next_data got=%h exp=%h", data, model_data); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    send_frame(8'h00, 1'b1, ^8'h00);
    total++; if (data !== 8'h00) begin bad++; $display("FAIL b2b_first_data got=%h exp=00", data); end
    send_frame(8'hFF, 1'b1, ^8'hFF);
    idle(4);
    model_data = 8'hFF;
    total++; if (n_valid - v0 !== 2) begin bad++; $display("FAIL b2b_valid_cnt got=%0d exp=2", n_valid - v0); end
    total++; if (last_valid_cyc - prev_valid_cyc !== int'(FRAME)) begin
      bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", last_valid_cyc - prev_valid_cyc, FRAME);
    end
    total++; if (data !== model_data) begin bad++; $display("FAIL b2b_second_data got=%h exp=%h", data, model_data); end
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    logic [7:0] b;
    b = 8'h5A;
    v0 = n_valid; e0 = n_err;
    rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CLKS) @(negedge clk);
    end
    rx = b[4];
    repeat (CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_data = 8'h00;
    idle(30);
    total++; if (data !== model_data) begin bad++; $display("FAIL rstmid_data got=%h exp=%h", data, model_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if ((n_valid - v0) + (n_err - e0) !== 0) begin
      bad++; $display("FAIL rstmid_pulses got=%0d exp=0", (n_valid - v0) + (n_err - e0));
    end
    send_frame(8'h81, 1'b1, ^8'h81);
    idle(4);
    model_data = 8'h81;
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL rstmid_next_valid got=%0d exp=1", n_valid - v0); end
    total++; if (data !== model_data) begin bad++; $display("FAIL rstmid_next_data got=%h exp=%h", data, model_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    model_data = 8'h07;
    total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL par_good_valid got=%0d exp=1", n_valid - v0); end
    total++; if (data !== model_data) begin bad++; $display("FAIL par_good_data got=%h exp=%h", data, model_data); end
    v0 = n_valid; e0 = n_err;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL par_bad_err got=%0d exp=1", n_err - e0); end
    total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL par_bad_valid got=%0d exp=0", n_valid - v0); end
  endtask
`endif

  task automatic test_random;
    int v0, e0;
    logic [7:0] b;
    logic stop, par, exp_err;
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      par  = (^b) ^ (PAR_EN && ($urandom_range(3) == 0));
      // Even parity: a good frame's parity bit equals the XOR of its data bits.
      exp_err = !stop || (par != ^b);
      v0 = n_valid; e0 = n_err;
      send_frame(b, stop, par);
      if (!exp_err) model_data = b;
      total++; if (n_valid - v0 !== (exp_err ? 0 : 1)) begin
        bad++; $display("FAIL rand_valid[%0d] byte=%h got=%0d exp=%0d", n, b, n_valid - v0, exp_err ? 0 : 1);
      end
      total++; if (n_err - e0 !== (exp_err ? 1 : 0)) begin
        bad++; $display("FAIL rand_err[%0d] byte=%h got=%0d exp=%0d", n, b, n_err - e0, exp_err ? 1 : 0);
      end
      total++; if (data !== model_data) begin
        bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", n, data, model_data);
      end
      if (!stop) begin
        repeat ($urandom_range(20)) @(negedge clk);
        idle(3 + $urandom_range(3));
      end else begin
        idle($urandom_range(3));
      end
    end
    idle(4);
  endtask

  task automatic test_pulse_shape;
    total++; if (max_valid_run !== 1) begin bad++; $display("FAIL valid_width got=%0d exp=1", max_valid_run); end
    total++; if (max_err_run !== 1) begin bad++; $display("FAIL err_width got=%0d exp=1", max_err_run); end
    total++; if (n_both !== 0) begin bad++; $display("FAIL valid_err_overlap got=%0d exp=0", n_both); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_good_frame();
    test_glitch();
    test_framing_err();
    test_back_to_back();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_pulse_shape();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the design's transmitter.
- Frame format: 8N1 (parity optional), LSB first.
- Deserializes an asynchronous serial line into bytes and presents each byte with a one-cycle valid strobe.
- Sits beside the transmitter in the top level. The serial input arrives on a dedicated input pin; received bytes drive uo_out or internal logic.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit period (100 MHz / 9600 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from detected falling edge to start-bit mid-sample (integer truncation).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- rx  input  1  asynchronous serial line; idles high.
- data  output  8  last correctly received byte; holds until the next good frame.
- data_valid  output  1  one-cycle pulse when data updates.
- frame_err  output  1  one-cycle pulse on a bad stop bit (or bad parity when enabled).
- busy  output  1  high while a frame is being received (any state other than IDLE).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0.
  - data=8'h00, data_valid=0, frame_err=0, busy=0.
  - Both synchronizer flops are set to 1, so reset does not produce a false start.
- Reset mid-frame aborts the frame immediately. No valid or error pulse is generated.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s, so there is a 2-cycle input latency.
- State machine:
  - IDLE:
    - rx_s==0 -> START, cycle counter cleared.
    - Otherwise stay in IDLE.
  - START:
    - Counts to HALF_BIT-1, then samples rx_s.
    - Sample 0 -> DATA, counter cleared.
    - Sample 1 -> IDLE (glitch rejection). No pulse on any output.
  - DATA:
    - Every CLKS_PER_BIT cycles, samples rx_s into shift bit [bit counter]. LSB is received first.
    - After the 8th sample, goes to STOP (or PARITY when enabled).
  - STOP: samples rx_s after CLKS_PER_BIT cycles.
    - Sample 1: data<=shift register and data_valid=1 on the next cycle; then IDLE.
    - Sample 0: frame_err=1 on the next cycle; data is unchanged; then BREAK.
  - BREAK:
    - Waits for rx_s==1, then goes to IDLE.
    - A held-low line (break condition) never generates further frames or errors.
- Output timing:
  - data_valid and frame_err are exactly 1 cycle wide.
  - data_valid and frame_err are never asserted together.
- Back-to-back frames:
  - The receiver is in IDLE one cycle after the stop sample, i.e. mid-stop-bit.
  - It accepts a new start edge immediately after that.
- Counters:
  - Cycle counter width is $clog2(CLKS_PER_BIT).
  - Bit counter is 3 bits.
  - Counters never wrap mid-bit; each state clears the cycle counter on exit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP; it samples one bit after CLKS_PER_BIT cycles.
  - Even parity: received parity bit must equal XOR of the 8 data bits.
  - A mismatch is latched, and the frame still proceeds through STOP.
  - At STOP: parity error or bad stop bit gives frame_err=1 and no data_valid.
  - If the stop bit is also low, the state then goes to BREAK.
  - Frame length is 11 bits.
- Undefined:
  - No PARITY state; 10-bit 8N1 frames.
  - No parity logic is synthesized.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Good frame: reset, then send 0xA5 as 8N1.
  - data_valid pulses exactly once, 1 cycle wide; data=8'hA5; frame_err stays 0.
  - busy falls 1 cycle after the stop sample.
- Glitch rejection: drive rx low for 4 cycles, then high.
  - Return to IDLE after HALF_BIT+2 cycles; busy pulses.
  - No data_valid or frame_err; data keeps its previous value.
- Framing error: send 0x3C with stop bit 0, hold rx low for 40 cycles, then release.
  - frame_err pulses once; data unchanged; no further pulses while low.
  - Next frame 0x3C after release is received correctly.
- Back-to-back: send 0x00 then 0xFF with no idle gap.
  - Two data_valid pulses, 160 cycles apart; data=0x00, then 0xFF.
- Reset mid-frame: assert rst_n=0 during data bit 4 of 0x5A, release, then send 0x81.
  - No pulse from the aborted frame; data=0x00 after reset; data=0x81 with a valid pulse.
- With UART_RX_PARITY_EN:
  - Send 0x07 with parity=1 -> data_valid, data=0x07.
  - Send 0x07 with parity=0 -> frame_err, no valid.
